// File: rtl/ram_fifo_pkg.sv
// Shared constants and helpers for the RAM-backed FIFO controller.
package ram_fifo_pkg;

  // Entries in the output stage that absorbs the RAM's one-cycle read latency.
  localparam int RAM_FIFO_STAGE_DEPTH = 2;

  // Pointer width for a RAM of 'depth' entries: address bits plus a wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ram_fifo_out_stage.sv
// Two-entry capture/pop buffer sitting behind the RAM read port.
// The caller guarantees a capture never arrives while both entries are full.
module ram_fifo_out_stage
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic                                           push,
  input  logic [WIDTH-1:0]                               push_data,
  input  logic                                           pop,
  output logic                                           head_valid,
  output logic [WIDTH-1:0]                               head_data,
  output logic [$clog2(RAM_FIFO_STAGE_DEPTH+1)-1:0]      stage_cnt
);

  localparam int CW = $clog2(RAM_FIFO_STAGE_DEPTH + 1);

  logic [RAM_FIFO_STAGE_DEPTH-1:0][WIDTH-1:0] slot;
  logic                                       wr_idx;
  logic                                       rd_idx;

  // Slot storage and ring indices; slots clear so the head reads 0 out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot   <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
    end else begin
      if (push) begin
        slot[wr_idx] <= push_data;
        wr_idx       <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
    end
  end

  // Occupancy: a capture and a pop in the same cycle cancel out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10:   stage_cnt <= stage_cnt + CW'(1);
        2'b01:   stage_cnt <= stage_cnt - CW'(1);
        default: stage_cnt <= stage_cnt;
      endcase
    end
  end

  assign head_valid = (stage_cnt != '0);
  assign head_data  = slot[rd_idx];

endmodule

// File: rtl/ram_fifo_controller.sv
// Streaming FIFO controller in front of a single-cycle synchronous RAM.
// Owns the write/read pointers and RAM request ports; the output stage
// hides the RAM's registered read latency.
// Optional status outputs (count, overflow) when RAM_FIFO_CTRL_STATUS_EN is defined.
module ram_fifo_controller
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       ram_write_valid,
  input  logic                       ram_write_ready,
  output logic [$clog2(DEPTH)-1:0]   ram_write_address,
  output logic [WIDTH-1:0]           ram_write_data,
  output logic                       ram_read_valid,
  input  logic                       ram_read_ready,
  output logic [$clog2(DEPTH)-1:0]   ram_read_address,
  input  logic [WIDTH-1:0]           ram_read_data
`ifdef RAM_FIFO_CTRL_STATUS_EN
  ,
  output logic [$clog2(DEPTH+2):0]   count,
  output logic                       overflow
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = ptr_width(DEPTH);
  localparam int SCW = $clog2(RAM_FIFO_STAGE_DEPTH + 1);
  localparam int NW  = SCW + 1;

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  ram_count;
  logic           ram_full;
  logic           ram_empty;
  logic           wr_fire;
  logic           rd_fire;
  logic           inflight;
  logic           pop;
  logic [SCW-1:0] stage_cnt;
  logic [NW-1:0]  stage_need;

  // Occupancy from registered pointers only, so a word is never read in the
  // cycle it is written and a same-cycle read does not reopen in_ready.
  assign ram_count = wr_ptr - rd_ptr;
  assign ram_full  = (ram_count == PW'(DEPTH));
  assign ram_empty = (ram_count == '0);

  assign ram_write_valid   = in_valid && !ram_full;
  assign in_ready          = !ram_full && ram_write_ready;
  assign ram_write_address = wr_ptr[AW-1:0];
  assign ram_write_data    = in_data;
  assign wr_fire           = ram_write_valid && ram_write_ready;

  // Only issue a read when the stage has room for it after this cycle's
  // pending capture and pop settle.
  assign pop              = out_valid && out_ready;
  assign stage_need       = NW'(stage_cnt) + NW'(inflight) - NW'(pop);
  assign ram_read_valid   = !ram_empty && (stage_need < NW'(RAM_FIFO_STAGE_DEPTH));
  assign ram_read_address = rd_ptr[AW-1:0];
  assign rd_fire          = ram_read_valid && ram_read_ready;

  // Pointer advance and the one-cycle in-flight marker for accepted reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + PW'(1);
      inflight <= rd_fire;
    end
  end

  ram_fifo_out_stage #(
    .WIDTH (WIDTH)
  ) u_out_stage (
    .clock      (clock),
    .reset      (reset),
    .push       (inflight),
    .push_data  (ram_read_data),
    .pop        (pop),
    .head_valid (out_valid),
    .head_data  (out_data),
    .stage_cnt  (stage_cnt)
  );

`ifdef RAM_FIFO_CTRL_STATUS_EN
  localparam int CW = $clog2(DEPTH + 2) + 1;

  // Words held anywhere: RAM, the read in flight, and the output stage.
  assign count = CW'(ram_count) + CW'(inflight) + CW'(stage_cnt);

  // Sticky record of a push attempted while the RAM was full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (in_valid && ram_full) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/ram_fifo_controller.md
# ram_fifo_controller

Initiator-side controller that turns the switch's single-cycle synchronous `ram` block into a streaming FIFO. It drives the RAM's write and read request ports and absorbs the one-cycle registered read latency with a two-entry output stage. Upstream and downstream use valid/ready handshakes. It sits between a port's frame-ingress logic and the egress scheduler, with a `ram` instance of matching `WIDTH`/`DEPTH` as packet storage.

## Interface
- `WIDTH`, 32: data word width; must equal the attached RAM's `WIDTH`.
- `DEPTH`, 8: RAM entries; power of two, ≥2.
- `clock`  input  1  clock.
- `reset`  input  1  reset, asynchronous, active-high.
- `in_valid`  input  1  upstream word present.
- `in_ready`  output  1  upstream word accepted when `in_valid && in_ready`.
- `in_data`  input  WIDTH  upstream word.
- `out_valid`  output  1  head word present.
- `out_ready`  input  1  downstream accepts head.
- `out_data`  output  WIDTH  head word.
- `ram_write_valid`  output  1  RAM write request.
- `ram_write_ready`  input  1  RAM write acknowledge (same cycle).
- `ram_write_address`  output  $clog2(DEPTH)  write slot.
- `ram_write_data`  output  WIDTH  write word.
- `ram_read_valid`  output  1  RAM read request.
- `ram_read_ready`  input  1  RAM read acknowledge (same cycle).
- `ram_read_address`  output  $clog2(DEPTH)  read slot.
- `ram_read_data`  input  WIDTH  registered RAM read data, valid the cycle after an accepted read.
- `count`  output  $clog2(DEPTH+2)+1  total words held (only with `RAM_FIFO_CTRL_STATUS_EN`).
- `overflow`  output  1  sticky push-while-full flag (only with `RAM_FIFO_CTRL_STATUS_EN`).

## Operation
- Pointers `wr_ptr` and `rd_ptr` are each `$clog2(DEPTH)+1` bits, with the MSB as the wrap bit. `ram_count = wr_ptr - rd_ptr`, taken modulo pointer width. RAM addresses are the pointer LSBs.
- `ram_full = (ram_count == DEPTH)`; `ram_empty = (ram_count == 0)`.
- Write path:
  - `ram_write_valid = in_valid && !ram_full`.
  - `in_ready = !ram_full && ram_write_ready`.
  - `ram_write_address = wr_ptr[LSBs]`; `ram_write_data = in_data`.
  - `wr_ptr` increments on `ram_write_valid && ram_write_ready`.
- Output stage:
  - Two-entry FIFO (`stage_cnt` 0..2), plus a 1-bit `inflight` flag for a read issued last cycle.
  - `pop = out_valid && out_ready`.
  - `out_valid = (stage_cnt != 0)`; `out_data` is always the stage head.
- Read issue:
  - `ram_read_valid = !ram_empty && (stage_cnt + inflight - pop) < 2`.
  - `ram_read_address = rd_ptr[LSBs]`.
  - `rd_ptr` increments on `ram_read_valid && ram_read_ready`.
  - `inflight` is set to that accept at every edge.
- Capture: when `inflight` is 1, `ram_read_data` is written into the stage at the clock edge. Capture and pop can occur in the same cycle; `stage_cnt` is then unchanged.
- `ram_empty` is computed from the registered `wr_ptr`, so a word is never read in its own write cycle.
- Simultaneous push and RAM read:
  - Allowed whenever `0 < ram_count < DEPTH`.
  - When `ram_full`, a read in the same cycle does not re-enable `in_ready` until the next cycle.
- Overflow: `in_valid` while `ram_full` is back-pressured and no data is lost. `overflow` marks the attempt only.
- Total capacity is DEPTH+2 words.

## Timing
- Reset values:
  - `in_ready` follows its combinational term from reset state, so it is 1 when `ram_write_ready` is 1.
  - `out_valid` 0, `out_data` 0.
  - `ram_write_valid` 0, `ram_read_valid` 0.
  - Both addresses 0.
  - Pointers, `stage_cnt`, `inflight` 0.
  - `count` 0, `overflow` 0.
- Reset mid-operation discards all words, including any in-flight read. The attached RAM clears on the same reset.
- Latency: a push accepted in cycle 0 into an empty FIFO:
  - read issued in cycle 1;
  - `ram_read_data` valid in cycle 2 and captured at its end;
  - `out_valid` high from cycle 3.
- Throughput: sustained one word per cycle in each direction when `out_ready` is held high.
- `out_valid` and `out_data` are held stable until `pop`.

## Configuration
- `RAM_FIFO_CTRL_STATUS_EN` defined:
  - `count` and `overflow` ports exist.
  - `count = ram_count + inflight + stage_cnt`, registered-consistent (reflects state after the last edge).
  - `overflow` sets on `in_valid && ram_full` and clears only on reset.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

## Structure
- Package `ram_fifo_pkg` holds:
  - `localparam`-style helper function `ptr_width(depth)`;
  - output-stage depth constant `RAM_FIFO_STAGE_DEPTH = 2`.
- Sub-module `ram_fifo_out_stage` is the two-entry capture/pop buffer, exposing `stage_cnt`. The top level keeps the pointers and RAM request logic.

## Test plan
- Reset, then push 0x11 in cycle 0 with `out_ready=1` -> `ram_read_valid` in cycle 1, `out_valid` with `out_data=0x11` in cycle 3, `count` returns to 0.
- Push 0x100..0x109 back-to-back (DEPTH=8) with `out_ready=0` -> `in_ready` drops after 8 RAM writes plus stage fill, so 10 words accepted in total. `overflow=1` once `in_valid` is seen while full. Then drain 10 words in order.
- Continuous push and pop for 64 words with `out_ready=1` -> one word per cycle in steady state, output in order, pointers wrap with no gaps or duplicates.
- Random `out_ready` toggling during streaming -> `out_data` stable whenever `out_valid && !out_ready`, no word lost or duplicated.
- Assert reset with 5 words held and a read in flight -> next cycle all outputs at reset values; a subsequent push of 0xAA emerges first, no stale data.
